// File: rtl/sqrt_share_arbiter.sv
// sqrt_share_arbiter
//
// Round-robin scheduler that shares one multicycle fixed-point square-root
// unit among N requesters. One operation is outstanding at a time. Negative
// operands are retired immediately with err, and a unit that never answers
// is retired with err after TIMEOUT wait cycles, so no lane can hang it.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-low reset (also resets the sqrt unit)
//   req[N]        per-lane request level, held until that lane's done bit
//   operand[N*W]  flattened operands, lane i at [i*W +: W]
//   sqrt_start    one-cycle start pulse to the square-root unit
//   sqrt_operand  registered operand, stable from start until retire
//   sqrt_ready    square-root unit completion pulse
//   sqrt_result   square-root unit result, valid with sqrt_ready
//   done[N]       one-hot, one-cycle completion pulse to the granted lane
//   result        registered result, valid in the done cycle and held after
//   err           valid with done: negative operand or timeout
//   grant_id      lane currently or last served
//   busy          high in every state except idle
module sqrt_share_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       operand,
    output logic                 sqrt_start,
    output logic [W-1:0]         sqrt_operand,
    input  logic                 sqrt_ready,
    input  logic [W-1:0]         sqrt_result,
    output logic [N-1:0]         done,
    output logic [W-1:0]         result,
    output logic                 err,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy
);

    localparam int unsigned GW = $clog2(N);
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CntLast  = CW'(TIMEOUT - 1);
    localparam logic [GW-1:0] LaneLast = GW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StRetire
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic [W-1:0]  result_q, result_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Unpack the flattened operand bus.
    logic [W-1:0] lane_op [N];

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            lane_op[i] = operand[i*W +: W];
        end
    end

    // Round-robin pick: first requesting lane scanning upward from last+1.
    // The wrap is explicit because N need not be a power of two.
    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] scan_idx;
    logic [W-1:0]  pick_op;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_q;
        scan_idx   = last_q;
        for (int unsigned i = 0; i < N; i++) begin
            scan_idx = (scan_idx == LaneLast) ? '0 : scan_idx + 1'b1;
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign pick_op = lane_op[pick_idx];

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    opnd_d  = pick_op;
                    if (pick_op[W-1]) begin
                        // Negative operand: never reaches the sqrt unit.
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = StRetire;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                // sqrt_ready during this cycle is deliberately ignored.
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // Ready takes priority over a coincident timeout.
                if (sqrt_ready) begin
                    result_d = sqrt_result;
                    err_d    = 1'b0;
                    state_d  = StRetire;
                end else if (cnt_q == CntLast) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = StRetire;
                end
            end
            StRetire: begin
                last_d  = grant_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            last_q   <= LaneLast;
            opnd_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decode flops only, so reset clears them immediately.
    always_comb begin
        done = '0;
        if (state_q == StRetire) begin
            done[grant_q] = 1'b1;
        end
    end

    assign sqrt_start   = (state_q == StIssue);
    assign busy         = (state_q != StIdle);
    assign sqrt_operand = opnd_q;
    assign result       = result_q;
    assign err          = err_q;
    assign grant_id     = grant_q;

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Self-checking bench for sqrt_share_arbiter: a behavioural square-root unit
// with programmable latency, plus a round-robin / timing reference model.
module tb_sqrt_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 8;
    localparam int GW = $clog2(N);

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] operand = '0;
    logic           sqrt_start;
    logic [W-1:0]   sqrt_operand;
    logic           sqrt_ready;
    logic [W-1:0]   sqrt_result;
    logic [N-1:0]   done;
    logic [W-1:0]   result;
    logic           err;
    logic [GW-1:0]  grant_id;
    logic           busy;

    int ntests = 0;
    int nfail  = 0;
    int exp_last;
    logic [W-1:0] ops [N];
    int model_lat = 1;
    bit early = 1'b0;
    int pend;
    logic [W-1:0] pend_res;

    typedef struct {
        int           lane;
        int           cyc;
        logic [W-1:0] res;
        logic         err;
        int           starts;
    } exp_t;

    sqrt_share_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .operand     (operand),
        .sqrt_start  (sqrt_start),
        .sqrt_operand(sqrt_operand),
        .sqrt_ready  (sqrt_ready),
        .sqrt_result (sqrt_result),
        .done        (done),
        .result      (result),
        .err         (err),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Q16.16 square root: floor(sqrt(op * 2^16)).
    function automatic logic [W-1:0] ref_sqrt(input logic [W-1:0] op);
        logic [63:0] x, t, r;
        x = {16'b0, op, 16'b0};
        r = 64'd0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return r[W-1:0];
    endfunction

    // Expected outcome of the next grant, from the arbitration rules.
    function automatic exp_t model(input logic [N-1:0] rq, input int last, input int lat);
        exp_t x;
        logic [W-1:0] op;
        x.lane = -1;
        for (int i = 1; i <= N; i++) begin
            int j;
            j = (last + i) % N;
            if (x.lane < 0 && rq[j]) x.lane = j;
        end
        if (x.lane < 0) x.lane = 0;
        op = ops[x.lane];
        if (op[W-1]) begin
            x.cyc = 1; x.res = '0; x.err = 1'b1; x.starts = 0;
        end else begin
            x.starts = 1;
            if (lat >= 1 && lat <= TO) begin
                x.cyc = 2 + lat; x.res = ref_sqrt(op); x.err = 1'b0;
            end else begin
                x.cyc = TO + 2; x.res = '0; x.err = 1'b1;
            end
        end
        return x;
    endfunction

    function automatic logic [W-1:0] rand_op();
        if ($urandom_range(0, 4) == 0) return $urandom | 32'h8000_0000;
        return $urandom & 32'h7fff_ffff;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) operand[i*W +: W] = ops[i];
    endtask

    // Behavioural square-root unit; also flags overlapping starts.
    initial begin
        sqrt_ready  = 1'b0;
        sqrt_result = '0;
        pend        = 0;
        pend_res    = '0;
        forever begin
            @(posedge clock);
            #1;
            sqrt_ready = 1'b0;
            if (!reset) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        sqrt_ready  = 1'b1;
                        sqrt_result = pend_res;
                    end
                end
                if (sqrt_start) begin
                    ntests++;
                    if (pend != 0) begin
                        nfail++;
                        $display("FAIL overlap: start while %0d cycles outstanding, want 0", pend);
                    end
                    pend     = model_lat;
                    pend_res = ref_sqrt(sqrt_operand);
                    if (early) begin
                        sqrt_ready  = 1'b1;
                        sqrt_result = 32'hdead_beef;
                    end
                end
            end
        end
    end

    // Watches from the current cycle (cycle 0) until a done pulse or maxc.
    task automatic observe(input int maxc, input int pl, output int cyc,
                           output logic [N-1:0] d, output logic [GW-1:0] g,
                           output logic [W-1:0] r, output logic e, output int starts,
                           output int st_cyc, output logic [W-1:0] st_op);
        cyc = -1; d = '0; g = '0; r = '0; e = 1'b0;
        starts = 0; st_cyc = -1; st_op = '0;
        for (int k = 0; k <= maxc; k++) begin
            @(negedge clock);
            if (sqrt_start) begin
                starts++;
                if (st_cyc < 0) begin
                    st_cyc = k;
                    st_op  = sqrt_operand;
                end
            end
            if (done != '0) begin
                cyc = k; d = done; g = grant_id; r = result; e = err;
                break;
            end
            if (k == 2 && pl >= 0) begin
                ops[pl] = ~ops[pl];
                drive_ops();
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        req = '0;
        for (int i = 0; i < N; i++) ops[i] = '0;
        drive_ops();
        repeat (3) @(negedge clock);
        ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst busy: got %b want 0", busy); end
        ntests++; if (sqrt_start !== 1'b0) begin nfail++; $display("FAIL rst start: got %b want 0", sqrt_start); end
        ntests++; if (done !== '0) begin nfail++; $display("FAIL rst done: got %b want 0", done); end
        ntests++; if (result !== '0) begin nfail++; $display("FAIL rst result: got %h want 0", result); end
        ntests++; if (err !== 1'b0) begin nfail++; $display("FAIL rst err: got %b want 0", err); end
        ntests++; if (grant_id !== '0) begin nfail++; $display("FAIL rst grant: got %0d want 0", grant_id); end
        ntests++; if (sqrt_operand !== '0) begin nfail++; $display("FAIL rst operand: got %h want 0", sqrt_operand); end
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst idle busy: got %b want 0", busy); end
        exp_last = N - 1;
    endtask

    task automatic test_single_lane();
        exp_t x; int cyc, starts, stc; logic [N-1:0] d, eh; logic [GW-1:0] g;
        logic [W-1:0] r, sto; logic e;
        @(posedge clock); #1;
        ops[2] = 32'h0004_0000; drive_ops();
        req = 4'b0100; model_lat = 5;
        x = model(req, exp_last, 5);
        observe(TO + 10, -1, cyc, d, g, r, e, starts, stc, sto);
        eh = '0; eh[x.lane] = 1'b1;
        ntests++; if (cyc !== x.cyc) begin nfail++; $display("FAIL single latency: got %0d want %0d", cyc, x.cyc); end
        ntests++; if (stc !== 1) begin nfail++; $display("FAIL single start cycle: got %0d want 1", stc); end
        ntests++; if (sto !== 32'h0004_0000) begin nfail++; $display("FAIL single sqrt_operand: got %h want 00040000", sto); end
        ntests++; if (d !== eh) begin nfail++; $display("FAIL single done: got %b want %b", d, eh); end
        ntests++; if (g !== GW'(x.lane)) begin nfail++; $display("FAIL single grant: got %0d want %0d", g, x.lane); end
        ntests++; if (r !== 32'h0002_0000) begin nfail++; $display("FAIL single result: got %h want 00020000", r); end
        ntests++; if (e !== 1'b0) begin nfail++; $display("FAIL single err: got %b want 0", e); end
        exp_last = x.lane;
        req = '0;
        @(negedge clock);
        ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL single busy after: got %b want 0", busy); end
        ntests++; if (result !== x.res) begin nfail++; $display("FAIL single result hold: got %h want %h", result, x.res); end
    endtask

    task automatic test_negative();
        exp_t x; int cyc, starts, stc; logic [N-1:0] d, eh; logic [GW-1:0] g;
        logic [W-1:0] r, sto; logic e;
        @(posedge clock); #1;
        ops[1] = 32'hffff_0000; drive_ops();
        req = 4'b0010; model_lat = 1;
        x = model(req, exp_last, 1);
        observe(TO + 10, -1, cyc, d, g, r, e, starts, stc, sto);
        eh = '0; eh[x.lane] = 1'b1;
        ntests++; if (cyc !== 1) begin nfail++; $display("FAIL neg latency: got %0d want 1", cyc); end
        ntests++; if (starts !== 0) begin nfail++; $display("FAIL neg starts: got %0d want 0", starts); end
        ntests++; if (d !== eh) begin nfail++; $display("FAIL neg done: got %b want %b", d, eh); end
        ntests++; if (r !== '0) begin nfail++; $display("FAIL neg result: got %h want 0", r); end
        ntests++; if (e !== 1'b1) begin nfail++; $display("FAIL neg err: got %b want 1", e); end
        exp_last = x.lane;
        req = '0;
    endtask

    task automatic test_round_robin();
        exp_t x; int cyc, starts, stc, lat; logic [N-1:0] d, eh; logic [GW-1:0] g;
        logic [W-1:0] r, sto; logic e;
        @(posedge clock); #1;
        for (int i = 0; i < N; i++) ops[i] = $urandom & 32'h7fff_ffff;
        drive_ops();
        req = '1;
        for (int t = 0; t < 6; t++) begin
            lat = $urandom_range(1, 4);
            model_lat = lat;
            x = model(req, exp_last, lat);
            observe(TO + 10, -1, cyc, d, g, r, e, starts, stc, sto);
            eh = '0; eh[x.lane] = 1'b1;
            ntests++; if (cyc !== x.cyc) begin nfail++; $display("FAIL rr[%0d] latency: got %0d want %0d", t, cyc, x.cyc); end
            ntests++; if (d !== eh) begin nfail++; $display("FAIL rr[%0d] done: got %b want %b", t, d, eh); end
            ntests++; if (g !== GW'(x.lane)) begin nfail++; $display("FAIL rr[%0d] grant: got %0d want %0d", t, g, x.lane); end
            ntests++; if (r !== x.res || e !== x.err) begin nfail++; $display("FAIL rr[%0d] result: got %h/%b want %h/%b", t, r, e, x.res, x.err); end
            ntests++; if (starts !== 1) begin nfail++; $display("FAIL rr[%0d] starts: got %0d want 1", t, starts); end
            exp_last = x.lane;
        end
        req = '0;
    endtask

    task automatic test_timeout();
        exp_t x; int cyc, starts, stc; logic [N-1:0] d, eh; logic [GW-1:0] g;
        logic [W-1:0] r, sto; logic e;
        @(posedge clock); #1;
        ops[0] = $urandom & 32'h7fff_ffff;
        ops[3] = $urandom & 32'h7fff_ffff;
        drive_ops();
        req = 4'b1001;
        for (int t = 0; t < 2; t++) begin
            model_lat = (t == 0) ? 0 : 2;
            x = model(req, exp_last, model_lat);
            observe(TO + 10, -1, cyc, d, g, r, e, starts, stc, sto);
            eh = '0; eh[x.lane] = 1'b1;
            ntests++; if (cyc !== x.cyc) begin nfail++; $display("FAIL timeout[%0d] latency: got %0d want %0d", t, cyc, x.cyc); end
            ntests++; if (d !== eh) begin nfail++; $display("FAIL timeout[%0d] done: got %b want %b", t, d, eh); end
            ntests++; if (r !== x.res) begin nfail++; $display("FAIL timeout[%0d] result: got %h want %h", t, r, x.res); end
            ntests++; if (e !== x.err) begin nfail++; $display("FAIL timeout[%0d] err: got %b want %b", t, e, x.err); end
            exp_last = x.lane;
            req[x.lane] = 1'b0;
        end
        req = '0;
    endtask

    task automatic test_tie_early();
        exp_t x; int cyc, starts, stc; logic [N-1:0] d; logic [GW-1:0] g;
        logic [W-1:0] r, sto; logic e;
        for (int t = 0; t < 2; t++) begin
            @(posedge clock); #1;
            ops[2] = $urandom & 32'h7fff_ffff; drive_ops();
            req = 4'b0100;
            early = (t == 0);
            model_lat = (t == 0) ? 3 : TO;
            x = model(req, exp_last, model_lat);
            observe(TO + 10, -1, cyc, d, g, r, e, starts, stc, sto);
            ntests++; if (cyc !== x.cyc) begin nfail++; $display("FAIL tie[%0d] latency: got %0d want %0d", t, cyc, x.cyc); end
            ntests++; if (r !== x.res) begin nfail++; $display("FAIL tie[%0d] result: got %h want %h", t, r, x.res); end
            ntests++; if (e !== 1'b0) begin nfail++; $display("FAIL tie[%0d] err: got %b want 0", t, e); end
            exp_last = x.lane;
            req = '0;
        end
        early = 1'b0;
    endtask

    task automatic test_random();
        exp_t x; int cyc, starts, stc, lat, nl; logic [N-1:0] d, eh, nr; logic [GW-1:0] g;
        logic [W-1:0] r, sto, eop; logic e;
        @(posedge clock); #1;
        for (int i = 0; i < N; i++) ops[i] = rand_op();
        drive_ops();
        req = N'($urandom_range(1, (1 << N) - 1));
        for (int t = 0; t < 30; t++) begin
            lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
            early = 1'($urandom_range(0, 1));
            model_lat = lat;
            x = model(req, exp_last, lat);
            eop = ops[x.lane];
            observe(TO + 10, x.lane, cyc, d, g, r, e, starts, stc, sto);
            eh = '0; eh[x.lane] = 1'b1;
            ntests++; if (cyc !== x.cyc) begin nfail++; $display("FAIL rnd[%0d] latency: got %0d want %0d", t, cyc, x.cyc); end
            ntests++; if (d !== eh || g !== GW'(x.lane)) begin nfail++; $display("FAIL rnd[%0d] grant: got %b/%0d want %b/%0d", t, d, g, eh, x.lane); end
            ntests++; if (r !== x.res || e !== x.err) begin nfail++; $display("FAIL rnd[%0d] result: got %h/%b want %h/%b", t, r, e, x.res, x.err); end
            ntests++; if (starts !== x.starts) begin nfail++; $display("FAIL rnd[%0d] starts: got %0d want %0d", t, starts, x.starts); end
            if (x.starts > 0) begin
                ntests++; if (sto !== eop) begin nfail++; $display("FAIL rnd[%0d] sqrt_operand: got %h want %h", t, sto, eop); end
            end
            exp_last = x.lane;
            req[x.lane] = 1'b0;
            nr = N'($urandom_range(0, (1 << N) - 1)) & ~req;
            for (int i = 0; i < N; i++) if (nr[i]) ops[i] = rand_op();
            req = req | nr;
            if (req == '0) begin
                nl = $urandom_range(0, N - 1);
                ops[nl] = rand_op();
                req[nl] = 1'b1;
            end
            drive_ops();
        end
        early = 1'b0;
        req = '0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        exp_t x; int cyc, starts, stc; logic [N-1:0] d, eh; logic [GW-1:0] g;
        logic [W-1:0] r, sto; logic e; bit stray;
        @(posedge clock); #1;
        ops[3] = $urandom & 32'h7fff_ffff; drive_ops();
        req = 4'b1000; model_lat = 0;
        repeat (4) @(negedge clock);
        ntests++; if (busy !== 1'b1) begin nfail++; $display("FAIL midrst busy before: got %b want 1", busy); end
        #2 reset = 1'b0;
        #1;
        ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL midrst busy: got %b want 0", busy); end
        ntests++; if (sqrt_start !== 1'b0 || done !== '0) begin nfail++; $display("FAIL midrst start/done: got %b/%b want 0/0", sqrt_start, done); end
        req = '0;
        repeat (2) @(negedge clock);
        @(posedge clock); #1 reset = 1'b1;
        stray = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (done !== '0) stray = 1'b1;
        end
        ntests++; if (stray) begin nfail++; $display("FAIL midrst stray done: got 1 want 0"); end
        exp_last = N - 1;
        @(posedge clock); #1;
        for (int i = 0; i < N; i++) ops[i] = $urandom & 32'h7fff_ffff;
        drive_ops();
        req = '1; model_lat = 1;
        x = model(req, exp_last, 1);
        observe(TO + 10, -1, cyc, d, g, r, e, starts, stc, sto);
        eh = '0; eh[x.lane] = 1'b1;
        ntests++; if (d !== eh || g !== GW'(x.lane)) begin nfail++; $display("FAIL midrst first grant: got %b/%0d want %b/%0d", d, g, eh, x.lane); end
        ntests++; if (cyc !== x.cyc) begin nfail++; $display("FAIL midrst latency: got %0d want %0d", cyc, x.cyc); end
        ntests++; if (r !== x.res || e !== x.err) begin nfail++; $display("FAIL midrst result: got %h/%b want %h/%b", r, e, x.res, x.err); end
        exp_last = x.lane;
        req = '0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_lane();
        test_negative();
        test_round_robin();
        test_timeout();
        test_tie_early();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/sqrt_share_arbiter.md
# sqrt_share_arbiter

Round-robin scheduler that shares one multicycle fixed-point square-root unit among `N` requesters, such as the normal-vector units of parallel intersection lanes. It takes a request and operand from each lane, issues one operation at a time to the square-root unit, and waits for completion. It then returns the result with a one-cycle done pulse to the winning lane. Negative operands and square-root-unit timeouts are retired with an error flag, so no lane can hang the shared resource.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8.
- `W`, 32: operand/result width; signed fixed-point, same format as `fixed`.
- `TIMEOUT`, 64: maximum cycles to wait for `sqrt_ready` before forced retire; must be ≥ 2.

Ports:
- `clock`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req`  in  N: per-lane request level; held high until that lane's `done` bit.
- `operand`  in  N*W: flattened operands; lane i occupies bits [i*W +: W].
- `sqrt_start`  out  1: one-cycle start pulse to the square-root unit.
- `sqrt_operand`  out  W: registered operand; stable from the start pulse until retire.
- `sqrt_ready`  in  1: square-root unit completion pulse.
- `sqrt_result`  in  W: square-root unit result; valid when `sqrt_ready` is high.
- `done`  out  N: one-hot, one-cycle completion pulse to the granted lane.
- `result`  out  W: registered result; valid in the `done` cycle.
- `err`  out  1: valid with `done`; 1 means a negative operand or a timeout.
- `grant_id`  out  $clog2(N): index of the lane currently or last served.
- `busy`  out  1: high in every state except IDLE.

## Operation
States: IDLE, ISSUE, WAIT, RETIRE.

**IDLE**
- If `req` ≠ 0, pick the first set bit scanning upward from `last+1` with wrap-around. `last` is the previously retired lane.
- Latch `grant_id`, and latch that lane's operand into `sqrt_operand`.
- If the operand MSB is 1 (negative), set `result` = 0 and `err` = 1, then go to RETIRE. The square-root unit is never started.
- Otherwise go to ISSUE.

**ISSUE**
- `sqrt_start` = 1 for exactly this cycle.
- Clear the timeout counter.
- Go to WAIT unconditionally. `sqrt_ready` in this cycle is ignored.

**WAIT**
- Increment the counter every cycle.
- If `sqrt_ready` = 1: latch `sqrt_result` into `result`, set `err` = 0, go to RETIRE.
- Else if the counter reaches `TIMEOUT`-1: set `result` = 0, `err` = 1, go to RETIRE.
- If `sqrt_ready` and the timeout coincide, `sqrt_ready` wins and `err` = 0.

**RETIRE**
- `done[grant_id]` = 1 for one cycle.
- Set `last` = `grant_id`.
- Go to IDLE.

Rules:
- A granted transaction always completes, even if its `req` drops mid-flight; `done` still pulses.
- Operand changes after the grant are ignored.
- `req` of other lanes is ignored while `busy`.
- Only one operation is ever outstanding at the square-root unit.
- Round-robin: after lane k retires, lane k has the lowest priority. With all lanes requesting continuously, service is 0,1,2,…,N-1,0,…
- Reset values: state IDLE, `last` = N-1 (so lane 0 wins first), all outputs 0, counter 0.
- Reset asserted mid-operation immediately returns to IDLE and deasserts `sqrt_start`, `done` and `busy`. No `done` is issued for the aborted transaction. The square-root unit must be reset by the same signal.

## Timing
- Cycle 0 (IDLE, `req` seen) → cycle 1 ISSUE (`sqrt_start`) → cycle 2+ WAIT.
- `sqrt_ready` sampled in WAIT cycle k → RETIRE (`done`, `result`) in cycle k+1 → IDLE in cycle k+2.
- Minimum turnaround with a one-cycle square-root latency (ready in the first WAIT cycle): `req` → `done` = 3 cycles; 4 cycles between successive grants.
- Negative operand: `done` and `err` in cycle 1; back to IDLE in cycle 2.
- Timeout: `done` with `err` exactly `TIMEOUT` WAIT cycles after ISSUE, i.e. cycle `TIMEOUT`+2 relative to cycle 0.
- All outputs are registered; there is no combinational path from `req` or `sqrt_ready` to any output.
- `result`, `err` and `grant_id` hold their values after RETIRE until the next grant.

## Test plan
- **Reset defaults and single lane.** After reset, lane 2 requests with operand 0x0004_0000 (4.0). The model unit returns 0x0002_0000 after 5 cycles. Expect: `sqrt_start` at cycle 1; `done` = 0b0100, `result` = 0x0002_0000 and `err` = 0 one cycle after `sqrt_ready`; `busy` low in the following cycle.
- **Round-robin fairness.** `req` = 0b1111 held continuously, with re-request after each `done`. Expect grant order 0,1,2,3,0,1 and exactly one `sqrt_start` outstanding at any time.
- **Negative operand.** Lane 1 requests with operand 0xFFFF_0000. Expect no `sqrt_start`, `done` = 0b0010 at cycle 1, `result` = 0, `err` = 1.
- **Timeout.** With `TIMEOUT` = 8, the unit never asserts `sqrt_ready`. Expect `done` with `err` = 1 and `result` = 0 at cycle 10. A second concurrent requester is then granted normally.
- **Ready/timeout tie and early ready.** (a) `sqrt_ready` pulsed during ISSUE is ignored. (b) `sqrt_ready` arrives in the same cycle the counter hits `TIMEOUT`-1: expect `err` = 0 and the real result.
- **Reset mid-WAIT.** Assert `reset` low during WAIT. Expect `busy`, `sqrt_start` and `done` to go to 0 asynchronously and no `done` afterwards. After release, with all lanes requesting, lane 0 is granted first.
